// File: rtl/fetch_seq_pkg.sv
// Shared types for the instruction fetch sequencer.
//   addr_t      : 32-bit byte address
//   instr_t     : 32-bit instruction word
//   state_t     : sequencer states (IDLE, FETCH, FLUSH)
//   buf_entry_t : instruction buffer payload (issue address + data)
//   PC_STEP     : fetch pointer increment per request
package fetch_seq_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    addr_t  pc;
    instr_t data;
  } buf_entry_t;

  localparam addr_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_buf.sv
// Synchronous instruction FIFO holding {pc, data} entries.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   clear           : drop all entries at the next clock edge
//   wrEn, wrEntry   : push an entry (accepted when not full, or full with a pop)
//   rdEn            : pop the head entry (ignored when empty)
//   rdEntry         : head entry, all-zero when empty
//   full, empty     : occupancy flags
//   count           : number of stored entries (0..DEPTH)
module fetch_buf
  import fetch_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wrEn,
  input  buf_entry_t               wrEntry,
  input  logic                     rdEn,
  output buf_entry_t               rdEntry,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  buf_entry_t      mem [DEPTH];
  logic [PW-1:0]   wrPtr;
  logic [PW-1:0]   rdPtr;
  logic [CW-1:0]   cnt;
  logic            doWr;
  logic            doRd;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign count = cnt;

  // A write into a full buffer is legal when the head leaves in the same cycle.
  assign doRd = rdEn && !empty;
  assign doWr = wrEn && (!full || doRd);

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doWr) wrPtr <= wrPtr + PW'(1);
      if (doRd) rdPtr <= rdPtr + PW'(1);
      if (doWr && !doRd)      cnt <= cnt + CW'(1);
      else if (doRd && !doWr) cnt <= cnt - CW'(1);
    end
  end

  // Storage array, no reset needed: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (doWr && !clear) mem[wrPtr] <= wrEntry;
  end

  assign rdEntry = empty ? '0 : mem[rdPtr];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues sequential ROM reads under credit
// control, buffers in-order responses with their addresses, and handles
// redirects by discarding responses still in flight.
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   imAddr, imAddr_vld      : ROM request (no backpressure)
//   imData, imData_vld      : ROM response (fixed latency, in order)
//   redirect, redirect_pc   : one-cycle restart request and new word-aligned address
//   instr, instr_pc         : head of instruction buffer and its address
//   instr_vld, instr_rdy    : head valid / core consumes head
// Optional (macro FETCH_SEQ_STATS_EN):
//   stall_cnt               : FETCH cycles with zero credits (saturating)
//   drop_cnt                : discarded responses (saturating)
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter addr_t       RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 8
)(
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imAddr,
  output logic        imAddr_vld,
  input  logic [31:0] imData,
  input  logic        imData_vld,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_vld,
  input  logic        instr_rdy
`ifdef FETCH_SEQ_STATS_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] drop_cnt
`endif
);

  localparam int unsigned OW  = $clog2(MAX_OUT + 1);
  localparam int unsigned BCW = $clog2(DEPTH) + 1;

  state_t          state;
  state_t          stateNext;
  addr_t           fetchPc;
  addr_t           fetchPcNext;
  addr_t           respPc;
  addr_t           respPcNext;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   outNext;
  logic [OW-1:0]   discard;
  logic [OW-1:0]   discardNext;
  logic            issue;
  logic            bufWr;
  logic            bufClear;
  logic            bufFull;
  logic            bufEmpty;
  logic [BCW-1:0]  occupancy;
  logic [31:0]     inUse;
  logic            creditAvail;
  logic            outRoom;
  buf_entry_t      wrEntry;
  buf_entry_t      headEntry;

  // Credits = DEPTH - occupancy - outstanding; they stay non-negative by construction.
  assign inUse       = 32'(occupancy) + 32'(outstanding);
  assign creditAvail = (inUse < 32'(DEPTH));
  assign outRoom     = (outstanding < OW'(MAX_OUT));

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fetchPc     <= RESET_PC;
      respPc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= stateNext;
      fetchPc     <= fetchPcNext;
      respPc      <= respPcNext;
      outstanding <= outNext;
      discard     <= discardNext;
    end
  end

  // Next-state, issue and buffer-write decisions.
  always_comb begin
    stateNext   = state;
    fetchPcNext = fetchPc;
    respPcNext  = respPc;
    outNext     = outstanding;
    discardNext = discard;
    issue       = 1'b0;
    bufWr       = 1'b0;
    bufClear    = 1'b0;

    case (state)
      IDLE:  stateNext = FETCH;
      FETCH: begin
        issue = !redirect && creditAvail && outRoom;
        if (issue) fetchPcNext = fetchPc + PC_STEP;
        // Kept responses arrive in issue order, so their address is a running pointer.
        if (imData_vld && !redirect) begin
          bufWr      = 1'b1;
          respPcNext = respPc + PC_STEP;
        end
      end
      FLUSH: begin
        if (imData_vld && !redirect) begin
          discardNext = discard - OW'(1);
          if (discard == OW'(1)) stateNext = FETCH;
        end
      end
      default: stateNext = IDLE;
    endcase

    if (issue && !imData_vld)      outNext = outstanding + OW'(1);
    else if (!issue && imData_vld) outNext = outstanding - OW'(1);

    // Redirect overrides everything: every response still owed gets discarded.
    if (redirect && (state != IDLE)) begin
      bufClear    = 1'b1;
      fetchPcNext = redirect_pc;
      respPcNext  = redirect_pc;
      discardNext = outNext;
      stateNext   = (outNext != '0) ? FLUSH : FETCH;
    end
  end

  assign wrEntry = '{pc: respPc, data: imData};

  fetch_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clear   (bufClear),
    .wrEn    (bufWr),
    .wrEntry (wrEntry),
    .rdEn    (instr_rdy),
    .rdEntry (headEntry),
    .full    (bufFull),
    .empty   (bufEmpty),
    .count   (occupancy)
  );

  assign imAddr     = fetchPc;
  assign imAddr_vld = issue;
  assign instr      = headEntry.data;
  assign instr_pc   = headEntry.pc;
  assign instr_vld  = !bufEmpty;

  // Credit accounting must keep writes away from a full buffer unless the head drains.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(bufWr && bufFull && !instr_rdy));

`ifdef FETCH_SEQ_STATS_EN
  logic dropEvt;

  assign dropEvt = imData_vld && ((state == FLUSH) || (redirect && (state != IDLE)));

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if ((state == FETCH) && !creditAvail && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (dropEvt && (drop_cnt != '1)) drop_cnt <= drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
module tb_fetch_sequencer;

  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 8;
  localparam int          LAT      = 3;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imAddr;
  logic        imAddr_vld;
  logic [31:0] imData;
  logic        imData_vld;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_vld;
  logic        instr_rdy;
`ifdef FETCH_SEQ_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] drop_cnt;
`endif

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned issueCnt    = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imAddr      (imAddr),
    .imAddr_vld  (imAddr_vld),
    .imData      (imData),
    .imData_vld  (imData_vld),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_vld   (instr_vld),
    .instr_rdy   (instr_rdy)
`ifdef FETCH_SEQ_STATS_EN
    ,
    .stall_cnt   (stall_cnt),
    .drop_cnt    (drop_cnt)
`endif
  );

  // sr_cpu style Fibonacci loop; addresses past it return distinct addi words.
  logic [31:0] prog [8] = '{32'h0000_0293, 32'h0010_0313, 32'h0062_83b3, 32'h0003_0293,
                            32'h0003_8313, 32'hff5f_f06f, 32'h0000_0013, 32'h0000_0013};

  function automatic logic [31:0] romWord(input logic [31:0] a);
    if (a < 32'd32) return prog[a[4:2]];
    return 32'h0000_0013 ^ {a[24:0], 7'd0};
  endfunction

  // ROM: fixed latency LAT, reset by the same rst.
  logic [LAT-1:0] pVld;
  logic [31:0]    pAddr [LAT];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pVld <= '0;
    end else begin
      pVld     <= {pVld[LAT-2:0], imAddr_vld};
      pAddr[0] <= imAddr;
      for (int i = 1; i < LAT; i++) pAddr[i] <= pAddr[i-1];
    end
  end
  assign imData_vld = pVld[LAT-1];
  assign imData     = romWord(pAddr[LAT-1]);

  // Behavioural model: queues of in-flight requests and buffered instructions.
  typedef struct packed {
    logic [31:0] pc;
    logic        keep;
  } flight_t;

  flight_t     flight [$];
  logic [31:0] bufPc [$];
  logic [31:0] bufData [$];
  logic [31:0] mPtr     = RESET_PC;
  bit          mStarted = 1'b0;
  int unsigned mDrops   = 0;
  int unsigned mStalls  = 0;

  function automatic bit anyDrop();
    foreach (flight[i]) if (!flight[i].keep) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit mIssue();
    return mStarted && !redirect && !anyDrop() &&
           (bufPc.size() + flight.size() < DEPTH) && (flight.size() < MAX_OUT);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      flight.delete();
      bufPc.delete();
      bufData.delete();
      mPtr     = RESET_PC;
      mStarted = 1'b0;
      mDrops   = 0;
      mStalls  = 0;
    end else begin
      bit      iss;
      flight_t f;
      iss = mIssue();
      if (mStarted && !anyDrop() && (bufPc.size() + flight.size() >= DEPTH)) mStalls++;
      if (mStarted && redirect) begin
        bufPc.delete();
        bufData.delete();
        if (imData_vld && flight.size() > 0) begin
          f = flight.pop_front();
          mDrops++;
        end
        foreach (flight[i]) flight[i].keep = 1'b0;
        mPtr = redirect_pc;
      end else begin
        if (instr_rdy && bufPc.size() > 0) begin
          void'(bufPc.pop_front());
          void'(bufData.pop_front());
        end
        if (imData_vld && flight.size() > 0) begin
          f = flight.pop_front();
          if (f.keep) begin
            bufPc.push_back(f.pc);
            bufData.push_back(romWord(f.pc));
          end else begin
            mDrops++;
          end
        end
        if (iss) begin
          flight.push_back('{pc: mPtr, keep: 1'b1});
          mPtr = mPtr + 32'd4;
        end
      end
      mStarted = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model plus a delivered-PC continuity check.
  logic [31:0] seqNext = RESET_PC;
  always @(negedge clk) begin
    bit eVld;
    eVld = bufPc.size() > 0;
    check("imAddr_vld", 32'(imAddr_vld), 32'(mIssue()));
    check("imAddr", imAddr, mPtr);
    check("instr_vld", 32'(instr_vld), 32'(eVld));
    if (eVld) begin
      check("instr_pc", instr_pc, bufPc[0]);
      check("instr", instr, bufData[0]);
    end
`ifdef FETCH_SEQ_STATS_EN
    check("drop_cnt", drop_cnt, mDrops);
    check("stall_cnt", stall_cnt, mStalls);
`endif
    if (imAddr_vld) issueCnt++;
    if (!rst && instr_vld && instr_rdy) begin
      check("pc_seq", instr_pc, seqNext);
      seqNext = instr_pc + 32'd4;
    end
    if (rst) seqNext = RESET_PC;
    else if (redirect && mStarted) seqNext = redirect_pc;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Returns at the start of the first cycle after reset release (state IDLE).
  task automatic doReset(input logic rdy);
    rst       = 1'b1;
    redirect  = 1'b0;
    instr_rdy = rdy;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_rdy   = 1'b1;
    #2 rst = 1'b1;

    // Reset values.
    mid();
    check("rst_imAddr", imAddr, RESET_PC);
    check("rst_imAddr_vld", 32'(imAddr_vld), 32'd0);
    check("rst_instr_vld", 32'(instr_vld), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);

    // Startup stream, instr_rdy = 1.
    doReset(1'b1);
    mid(); check("a_idle", 32'(imAddr_vld), 32'd0);
    cyc(); mid(); check("a_vld1", 32'(imAddr_vld), 32'd1); check("a_addr1", imAddr, 32'h0);
    cyc(); mid(); check("a_vld2", 32'(imAddr_vld), 32'd1); check("a_addr2", imAddr, 32'h4);
    cyc(); mid(); check("a_vld3", 32'(imAddr_vld), 32'd1); check("a_addr3", imAddr, 32'h8);
    cyc(); mid(); check("a_novld", 32'(instr_vld), 32'd0);
    cyc(); mid(); check("a_first_vld", 32'(instr_vld), 32'd1);
    check("a_first_pc", instr_pc, 32'h0); check("a_first_instr", instr, 32'h0000_0293);
    repeat (10) cyc();

    // Core stalled: exactly DEPTH requests, then resume within a cycle.
    doReset(1'b0);
    issueCnt = 0;
    repeat (20) cyc();
    mid();
    check("b_issues", issueCnt, 32'd4);
    check("b_held", 32'(imAddr_vld), 32'd0);
    cyc(); instr_rdy = 1'b1;
    mid(); check("b_still_full", 32'(imAddr_vld), 32'd0);
    cyc(); mid(); check("b_resume", 32'(imAddr_vld), 32'd1); check("b_resume_addr", imAddr, 32'h10);
    repeat (8) cyc();

    // Redirect to 0x40 with 3 outstanding (one response landing that cycle).
    doReset(1'b1);
    cyc(); cyc(); cyc();
    cyc(); redirect = 1'b1; redirect_pc = 32'h40;
    mid(); check("c_redir_noissue", 32'(imAddr_vld), 32'd0);
    cyc(); redirect = 1'b0;
    mid(); check("c_flush1", 32'(imAddr_vld), 32'd0); check("c_flush_instr", 32'(instr_vld), 32'd0);
    cyc(); mid(); check("c_flush2", 32'(imAddr_vld), 32'd0);
    cyc(); mid(); check("c_issue", 32'(imAddr_vld), 32'd1); check("c_addr", imAddr, 32'h40);
`ifdef FETCH_SEQ_STATS_EN
    check("c_drops", drop_cnt, 32'd3);
`endif
    cyc(); cyc(); cyc();
    cyc(); mid(); check("c_first_vld", 32'(instr_vld), 32'd1); check("c_first_pc", instr_pc, 32'h40);
    repeat (6) cyc();

    // Redirect in FLUSH coinciding with the last owed response.
    doReset(1'b1);
    cyc();
    cyc(); redirect = 1'b1; redirect_pc = 32'h80;
    mid(); check("d_redir1", 32'(imAddr_vld), 32'd0);
    cyc(); redirect = 1'b0;
    mid(); check("d_flush", 32'(imAddr_vld), 32'd0);
    cyc(); redirect = 1'b1; redirect_pc = 32'h40;
    mid(); check("d_redir2", 32'(imAddr_vld), 32'd0);
    cyc(); redirect = 1'b0;
    mid(); check("d_issue", 32'(imAddr_vld), 32'd1); check("d_addr", imAddr, 32'h40);
`ifdef FETCH_SEQ_STATS_EN
    check("d_drops", drop_cnt, 32'd1);
`endif
    repeat (6) cyc();

    // Reset mid-stream with 2 outstanding.
    doReset(1'b1);
    cyc(); cyc(); cyc();
    rst = 1'b1;
    #1;
    check("e_rst_addr", imAddr, RESET_PC);
    check("e_rst_vld", 32'(imAddr_vld), 32'd0);
    check("e_rst_instr_vld", 32'(instr_vld), 32'd0);
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      mid();
      check("e_no_instr", 32'(instr_vld), 32'd0);
      if (c == 1) check("e_restart", imAddr, RESET_PC);
      cyc();
    end

    // Random consumer with occasional redirects.
    for (int n = 0; n < 1000; n++) begin
      instr_rdy   = 1'($urandom_range(0, 3) != 0);
      redirect    = 1'($urandom_range(0, 39) == 0);
      redirect_pc = 32'($urandom_range(0, 15)) << 2;
      cyc();
    end
    redirect = 1'b0;
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
